// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared types and constants for the DAC0832 scheduler
package dac_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, WR1, HOLD, XFER, DONE} state_t;

  localparam int DAC_DW = 8;

  // {cs_, wr1_, wr2_, xfer_} with every strobe released
  localparam logic [3:0] CTRL_IDLE = 4'b1111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dac0832_scheduler_rr_arbiter.sv
// rtl/dac0832_scheduler_rr_arbiter.sv - combinational round-robin pick
module rr_arbiter
  import dac_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] winner,
  output logic [PW-1:0]   winner_idx
);

  int   k;
  logic found;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    k          = 0;
    for (int off = 0; off < NREQ; off++) begin
      k = (int'(pointer) + off) % NREQ;
      if (!found && req[k]) begin
        winner[k]  = 1'b1;
        winner_idx = PW'(k);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dac0832_scheduler.sv
// rtl/dac0832_scheduler.sv - round-robin DAC0832 dual-buffer write sequencer
// Optional 16-bit conversion counter port enabled by DAC_CONV_CNT_EN.
module dac0832_scheduler
  import dac_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DW        = DAC_DW,
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              done,
  output logic              ile,
  output logic              cs_,
  output logic              wr1_,
  output logic              wr2_,
  output logic              xfer_,
  output logic [DW-1:0]     dac_data
`ifdef DAC_CONV_CNT_EN
  ,
  output logic [15:0]       conv_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(max3(SETUP_CYC, WR_CYC, HOLD_CYC)) + 1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   win_idx;
  logic            accept;
  logic [3:0]      ctrl_n;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req        (req_valid),
    .pointer    (ptr),
    .winner     (win),
    .winner_idx (win_idx)
  );

  assign req_ready = (state == IDLE) ? win : '0;
  assign accept    = |(req_valid & req_ready);

  // Counter loads (cycles-1) on entry; a state exits once it reaches zero.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ctrl_n  = CTRL_IDLE;
    if (state == IDLE) begin
      if (accept) begin
        state_n = SETUP;
        cnt_n   = CW'(SETUP_CYC - 1);
      end
    end else if (cnt != '0) begin
      cnt_n = cnt - 1'b1;
    end else begin
      case (state)
        SETUP:   begin state_n = WR1;  cnt_n = CW'(WR_CYC - 1);   end
        WR1:     begin state_n = HOLD; cnt_n = CW'(HOLD_CYC - 1); end
        HOLD:    begin state_n = XFER; cnt_n = CW'(WR_CYC - 1);   end
        XFER:    begin state_n = DONE; cnt_n = '0;                end
        default: begin state_n = IDLE; cnt_n = '0;                end
      endcase
    end
    case (state_n)
      SETUP, HOLD: ctrl_n = 4'b0111;
      WR1:         ctrl_n = 4'b0011;
      XFER:        ctrl_n = 4'b1100;
      default:     ctrl_n = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state                  <= IDLE;
      cnt                    <= '0;
      ptr                    <= '0;
      ile                    <= 1'b0;
      {cs_, wr1_, wr2_, xfer_} <= CTRL_IDLE;
      dac_data               <= '0;
      grant                  <= '0;
      busy                   <= 1'b0;
      done                   <= 1'b0;
    end else begin
      state                  <= state_n;
      cnt                    <= cnt_n;
      ile                    <= 1'b1;
      {cs_, wr1_, wr2_, xfer_} <= ctrl_n;
      busy                   <= (state_n != IDLE);
      done                   <= (state_n == DONE);
      if (accept) begin
        dac_data <= req_data[win_idx*DW +: DW];
        grant    <= win;
        ptr      <= (int'(win_idx) + 1 == NREQ) ? '0 : win_idx + 1'b1;
      end else if (state_n == DONE) begin
        grant <= '0;
      end
    end
  end

`ifdef DAC_CONV_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_)
      conv_cnt <= '0;
    else if (state_n == DONE)
      conv_cnt <= conv_cnt + 16'd1;
  end
`endif

endmodule
